coeff_recomposer: RTL
=====================

Name: coeff_recomposer

Overview:
- Inverse of the Dilithium coefficient decomposer. Takes OUTPUT_W lanes of (r1, r0) pairs and rebuilds r = (r1*alpha + r0) mod Q.
- alpha = 2*gamma2, selected per beat by sec_lvl.
- Sits after the hint/high-bits path when w1/w0 must be reassembled into full coefficients before packing or NTT reuse.
- Two-stage valid/ready pipeline, same handshake naming as the decomposer.

Parameters:
- OUTPUT_W, 4: number of coefficient lanes per beat.
- COEFF_W, 24: width of one lane (r1, r0, r).
- Q, 23'd8380417: Dilithium modulus.
- N1, 18'd190464: alpha for sec_lvl 2 ((Q-1)/44).
- N2, 19'd523776: alpha for sec_lvl 3/5 ((Q-1)/16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- sec_lvl  in  3  security level, sampled with each accepted beat.
- valid_i  in  1  upstream beat valid.
- ready_i  out  1  block can accept a beat.
- dia  in  OUTPUT_W*COEFF_W  packed r1 lanes; lane k = bits [k*COEFF_W +: COEFF_W].
- dib  in  OUTPUT_W*COEFF_W  packed r0 lanes, each encoded as r0 mod Q in [0,Q).
- do  out  OUTPUT_W*COEFF_W  packed reconstructed r lanes in [0,Q).
- valid_o  out  1  output beat valid.
- ready_o  in  1  downstream ready.

Behaviour:
- Reset: asynchronous assert when rst=0. Clears stage valids, valid_o=0, do=0, ready_i=0 while in reset. ready_i=1 in the first cycle after release. Reset mid-operation discards all in-flight beats.
- Accept: a beat transfers when valid_i && ready_i at a clk edge.
- Output: a beat leaves when valid_o && ready_o.
- alpha selection: sec_lvl==3'b010 uses N1; every other value uses N2. The selection is registered with the beat in stage 1, so a sec_lvl change between beats has no effect on beats already in flight.
- Stage 1: per lane, p = r1*alpha, 24-bit. Implemented as constant shift-add, no generic multiplier. r0 and the alpha select are registered alongside.
- Stage 2 (output register): per lane, s = p + r0 at 25 bits. Output s-Q if s>=Q, else s.
  - Range guarantee: max r1*alpha is 43*N1=8189952 or 15*N2=7856640, both < Q. So s < 2Q and one conditional subtract suffices.
- Out-of-range inputs (r1 > 43 for lvl 2, r1 > 15 otherwise, or r0 >= Q): output is p+r0 reduced once, truncated to COEFF_W. Not otherwise defined; see the optional feature.
- Latency: 2 cycles from accept to valid_o with ready_o held high. Throughput is 1 beat/cycle.
- Backpressure:
  - Each stage advances when the next stage is empty or is being emptied in the same cycle.
  - ready_i = !s1_valid || s1 advancing.
  - With ready_o low, at most 2 beats are held, then ready_i drops.
  - do and valid_o stay stable while valid_o && !ready_o.
- Simultaneous accept and emit in the same cycle is fully supported with no bubble.
- When valid_o=0, do holds its last value and is don't-care to the consumer.

Optional Feature:
- Macro: RECOMP_RANGE_CHK_EN.
- When defined:
  - Adds output err_o (1 bit), reset 0.
  - err_o is sticky: set on any accepted beat where some lane violates the r1 bound for its sec_lvl or has r0 >= Q.
  - Cleared only by rst.
  - Set in the cycle after the offending accept.
  - Data path behaviour is unchanged.
- When undefined: port err_o is absent and no check logic is synthesised.

Test Plan:
- Reset/idle: rst=0 then 1, valid_i=0 -> valid_o=0, do=0, ready_i=1 after release.
- sec_lvl=2, all lanes r1=43, r0=8380416 -> every lane 8189951 exactly 2 cycles later. Also all lanes r1=0, r0=0 -> 0.
- sec_lvl=2, r1=1, r0=8285186 (i.e. -95231) -> 95233. sec_lvl=3, r1=15, r0=261888 -> 8118528. Mixed lanes give independent per-lane results.
- Backpressure: 3 consecutive beats with ready_o=0 -> ready_i falls after 2 accepts and the first result is held stable. Raise ready_o -> results emerge in order with no loss or duplication.
- Streaming: valid_i and ready_o high for 16 beats with sec_lvl alternating 2/5 per beat -> 16 outputs on consecutive cycles, each using its own beat's alpha.
- Reset mid-flight with 2 beats held -> valid_o=0 immediately. No stale beat appears after release. With RECOMP_RANGE_CHK_EN, r1=44 at sec_lvl 2 -> err_o=1 until reset.

Source files
------------

// File: rtl/coeff_recomposer.sv
`default_nettype none
// ============================================================================
// Module   : coeff_recomposer
// Purpose  : Rebuilds Dilithium coefficients r = (r1*alpha + r0) mod Q per lane
//            in a two-stage valid/ready pipeline. Optional sticky range flag
//            err_o is enabled by defining RECOMP_RANGE_CHK_EN.
// Revision : 1.0
// ============================================================================
module coeff_recomposer #(
    parameter int          OUTPUT_W = 4,
    parameter int          COEFF_W  = 24,
    parameter logic [22:0] Q        = 23'd8380417,
    parameter logic [17:0] N1       = 18'd190464,
    parameter logic [18:0] N2       = 19'd523776
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    sec_lvl,
    input  logic                          valid_i,
    output logic                          ready_i,
    input  logic [OUTPUT_W*COEFF_W-1:0]   dia,
    input  logic [OUTPUT_W*COEFF_W-1:0]   dib,
    output logic [OUTPUT_W*COEFF_W-1:0]   dout,
    output logic                          valid_o,
    input  logic                          ready_o
`ifdef RECOMP_RANGE_CHK_EN
    ,
    output logic                          err_o
`endif
);

    localparam logic [COEFF_W-1:0] c_q     = COEFF_W'(Q);
    localparam logic [COEFF_W:0]   c_q_ext = {1'b0, c_q};
    localparam logic [COEFF_W-1:0] c_n1    = COEFF_W'(N1);
    localparam logic [COEFF_W-1:0] c_n2    = COEFF_W'(N2);

    // Multiplication by an elaboration-time constant: collapses to a fixed
    // set of shifted adds, one per set bit of k.
    function automatic logic [COEFF_W-1:0] f_mul_const(input logic [COEFF_W-1:0] x,
                                                       input logic [COEFF_W-1:0] k);
        logic [COEFF_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < COEFF_W; i++) begin
            if (k[i]) acc = acc + (x << i);
        end
        return acc;
    endfunction

    logic w_lvl2;
    logic w_s2_load;
    logic w_s1_adv;
    logic w_accept;
    logic r_s1_valid;
    logic r_valid_o;

    assign w_lvl2    = (sec_lvl == 3'b010);
    assign w_s2_load = !r_valid_o || ready_o;
    assign w_s1_adv  = r_s1_valid && w_s2_load;
    assign ready_i   = rst && (!r_s1_valid || w_s2_load);
    assign w_accept  = valid_i && ready_i;
    assign valid_o   = r_valid_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_o <= 1'b0;
        end else if (w_s2_load) begin
            r_valid_o <= r_s1_valid;
        end
    end

`ifdef RECOMP_RANGE_CHK_EN
    localparam logic [COEFF_W-1:0] c_r1_max1 = (c_q - COEFF_W'(1)) / c_n1 - COEFF_W'(1);
    localparam logic [COEFF_W-1:0] c_r1_max2 = (c_q - COEFF_W'(1)) / c_n2 - COEFF_W'(1);
    logic [OUTPUT_W-1:0] w_lane_bad;
`endif

    generate
        for (genvar k = 0; k < OUTPUT_W; k++) begin : g_lane
            logic [COEFF_W-1:0] w_r1;
            logic [COEFF_W-1:0] w_r0;
            logic [COEFF_W-1:0] w_p;
            logic [COEFF_W:0]   w_sum;
            logic [COEFF_W:0]   w_red;
            logic [COEFF_W-1:0] r_p;
            logic [COEFF_W-1:0] r_r0;
            logic [COEFF_W-1:0] r_out;

            assign w_r1 = dia[k*COEFF_W +: COEFF_W];
            assign w_r0 = dib[k*COEFF_W +: COEFF_W];
            assign w_p  = w_lvl2 ? f_mul_const(w_r1, c_n1) : f_mul_const(w_r1, c_n2);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_p  <= '0;
                    r_r0 <= '0;
                end else if (w_accept) begin
                    r_p  <= w_p;
                    r_r0 <= w_r0;
                end
            end

            // In-range operands keep s below 2Q, so a single subtract reduces it.
            assign w_sum = {1'b0, r_p} + {1'b0, r_r0};
            assign w_red = (w_sum >= c_q_ext) ? (w_sum - c_q_ext) : w_sum;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_out <= '0;
                end else if (w_s1_adv) begin
                    r_out <= w_red[COEFF_W-1:0];
                end
            end

            assign dout[k*COEFF_W +: COEFF_W] = r_out;

`ifdef RECOMP_RANGE_CHK_EN
            assign w_lane_bad[k] = (w_lvl2 ? (w_r1 > c_r1_max1) : (w_r1 > c_r1_max2))
                                   || (w_r0 >= c_q);
`endif
        end
    endgenerate

`ifdef RECOMP_RANGE_CHK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_accept && (|w_lane_bad)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

endmodule
`default_nettype wire
